// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state and grant encodings for the memory-port arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I, RELEASE} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between I-cache and D-cache, D first with I starvation guard
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BLOCK_WIDTH  = 128,
  parameter int ADDR_WIDTH   = 28,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   IMEM_READ,
  input  logic [ADDR_WIDTH-1:0]  IMEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] IMEM_READDATA,
  output logic                   IMEM_BUSYWAIT,
  input  logic                   DMEM_READ,
  input  logic                   DMEM_WRITE,
  input  logic [ADDR_WIDTH-1:0]  DMEM_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] DMEM_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] DMEM_READDATA,
  output logic                   DMEM_BUSYWAIT,
  output logic                   MEM_READ,
  output logic                   MEM_WRITE,
  output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT,
  output logic                   STALL_OUT
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  state_t state;
  grant_t grant;
  logic [CW-1:0] cnt;
  logic first;
  logic d_req;
  assign d_req = DMEM_READ | DMEM_WRITE;
  assign IMEM_BUSYWAIT = IMEM_READ & ~(state == RELEASE && grant == GNT_I);
  assign DMEM_BUSYWAIT = d_req & ~(state == RELEASE && grant == GNT_D);
  assign STALL_OUT = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      grant         <= GNT_NONE;
      cnt           <= '0;
      first         <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      IMEM_READDATA <= '0;
      DMEM_READDATA <= '0;
    end else begin
      if (!IMEM_READ) cnt <= '0;
      case (state)
        IDLE: begin
          // D wins unless I has already waited through LIM consecutive D grants
          if (d_req && (!IMEM_READ || cnt < LIM)) begin
            state         <= SERVE_D;
            grant         <= GNT_D;
            first         <= 1'b1;
            MEM_READ      <= DMEM_READ;
            MEM_WRITE     <= DMEM_WRITE;
            MEM_ADDRESS   <= DMEM_ADDRESS;
            MEM_WRITEDATA <= DMEM_WRITEDATA;
            cnt           <= IMEM_READ ? cnt + 1'b1 : '0;
          end else if (IMEM_READ) begin
            state       <= SERVE_I;
            grant       <= GNT_I;
            first       <= 1'b1;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= IMEM_ADDRESS;
            cnt         <= '0;
          end
        end
        SERVE_D, SERVE_I: begin
          // memory may not have raised busywait yet on the strobe's first cycle
          if (first) first <= 1'b0;
          else if (!MEM_BUSYWAIT) begin
            if (MEM_READ && grant == GNT_I) IMEM_READDATA <= MEM_READDATA;
            if (MEM_READ && grant == GNT_D) DMEM_READDATA <= MEM_READDATA;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end
endmodule
